// File: rtl/log_db_scaler.sv
// Scales the fix32_24 ln() stream by COEF (Q4.28, default 10/ln10 -> dB), rounds half up,
// and queues results in a show-ahead FIFO. Define LOG_DB_SAT_EN to clamp instead of wrap.
module log_db_scaler #(
   parameter logic [31:0] COEF      = 32'd1165800373,
   parameter int unsigned COEF_FRAC = 28,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned LW        = $clog2(DEPTH) + 1
) (
   input  logic          i_clk,
   input  logic          i_arst,
   input  logic          i_valid_in,
   input  logic [31:0]   i_data_in,
   output logic          o_valid_out,
   input  logic          i_ready,
   output logic [31:0]   o_data_out,
   output logic [LW-1:0] o_level,
   output logic          o_overflow,
   input  logic          i_clr_ovf
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic signed [63:0] RND = 64'sd1 <<< (COEF_FRAC - 1);

   logic               s1_valid;
   logic signed [31:0] s1_data;
   logic               s2_valid;
   logic signed [63:0] s2_prod;
   logic               s3_valid;
   logic        [31:0] s3_data;

   logic signed [63:0] mul_a;
   logic signed [63:0] mul_b;
   logic        [31:0] r32;

   logic [31:0]   mem [DEPTH];
   logic [LW-1:0] wr_ptr;
   logic [LW-1:0] rd_ptr;
   logic [LW-1:0] rd_nxt;
   logic [LW-1:0] level_nxt;
   logic [31:0]   head_nxt;
   logic          full;
   logic          pop;
   logic          push;
   logic          drop;

   always_comb begin
      mul_a = {{32{s1_data[31]}}, s1_data};
      mul_b = {32'b0, COEF};
   end

`ifdef LOG_DB_SAT_EN
   localparam logic signed [63:0] MAX32 = 64'sd2147483647;
   localparam logic signed [63:0] MIN32 = -64'sd2147483648;
   logic signed [63:0] rounded;

   always_comb begin
      rounded = (s2_prod + RND) >>> COEF_FRAC;
      if (rounded > MAX32)
         r32 = 32'h7FFF_FFFF;
      else if (rounded < MIN32)
         r32 = 32'h8000_0000;
      else
         r32 = rounded[31:0];
   end
`else
   always_comb begin
      r32 = 32'((s2_prod + RND) >>> COEF_FRAC);
   end
`endif

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s2_valid <= 1'b0;
         s2_prod  <= '0;
         s3_valid <= 1'b0;
         s3_data  <= '0;
      end else begin
         s1_valid <= i_valid_in;
         if (i_valid_in)
            s1_data <= i_data_in;
         s2_valid <= s1_valid;
         s2_prod  <= mul_a * mul_b;
         s3_valid <= s2_valid;
         s3_data  <= r32;
      end
   end

   // A full FIFO still accepts a push when the head is popped in the same cycle.
   always_comb begin
      full = (o_level == LW'(DEPTH));
      pop  = o_valid_out & i_ready;
      push = s3_valid & (~full | pop);
      drop = s3_valid & full & ~pop;

      level_nxt = o_level;
      if (push && !pop)
         level_nxt = o_level + LW'(1);
      else if (pop && !push)
         level_nxt = o_level - LW'(1);

      rd_nxt = pop ? rd_ptr + LW'(1) : rd_ptr;

      // Writing into an empty (or just-drained) FIFO bypasses memory into the head register.
      if (push && (o_level - LW'(pop)) == '0)
         head_nxt = s3_data;
      else
         head_nxt = mem[rd_nxt[AW-1:0]];
   end

   always_ff @(posedge i_clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= s3_data;
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         o_level     <= '0;
         o_valid_out <= 1'b0;
         o_data_out  <= '0;
         o_overflow  <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + LW'(1);
         rd_ptr      <= rd_nxt;
         o_level     <= level_nxt;
         o_valid_out <= (level_nxt != '0);
         if (level_nxt != '0)
            o_data_out <= head_nxt;
         if (drop)
            o_overflow <= 1'b1;
         else if (i_clr_ovf)
            o_overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_log_db_scaler.sv
// Directed bench for log_db_scaler: rounding, latency, ordering, FIFO full/overflow,
// simultaneous push/pop when full, large-COEF wrap/clamp, and async reset flush.
module tb_log_db_scaler;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [31:0] data_in;
   logic        valid_out;
   logic        ready;
   logic [31:0] data_out;
   logic [3:0]  level;
   logic        overflow;
   logic        clr_ovf;

   logic        b_valid_in;
   logic [31:0] b_data_in;
   logic        b_valid_out;
   logic [31:0] b_data_out;
   logic [3:0]  b_level;
   logic        b_overflow;

   always #5 clk = ~clk;

   log_db_scaler #(.DEPTH(8)) u_dut (
      .i_clk(clk), .i_arst(rst), .i_valid_in(valid_in), .i_data_in(data_in),
      .o_valid_out(valid_out), .i_ready(ready), .o_data_out(data_out),
      .o_level(level), .o_overflow(overflow), .i_clr_ovf(clr_ovf)
   );

   log_db_scaler #(.COEF(32'hFFFF_FFFF), .DEPTH(8)) u_big (
      .i_clk(clk), .i_arst(rst), .i_valid_in(b_valid_in), .i_data_in(b_data_in),
      .o_valid_out(b_valid_out), .i_ready(1'b1), .o_data_out(b_data_out),
      .o_level(b_level), .o_overflow(b_overflow), .i_clr_ovf(1'b0)
   );

   typedef struct {
      int din;
      int exp;
      int tol;
   } vec_t;

   vec_t vecs[18];
   int   kexp[9];
   int   pass_cnt = 0;
   int   total_cnt = 0;
   bit   mon_en = 1'b0;
   logic [31:0] got_q[$];
   logic [31:0] big_q[$];

   always @(negedge clk) begin
      if (mon_en && valid_out && ready)
         got_q.push_back(data_out);
      if (mon_en && b_valid_out)
         big_q.push_back(b_data_out);
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp)
         pass_cnt++;
      else
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic chk_tol(input string name, input int got, input int exp, input int tol);
      int diff;
      diff = got - exp;
      total_cnt++;
      if (diff <= tol && diff >= -tol)
         pass_cnt++;
      else
         $display("FAIL %s: got %0d expected %0d +-%0d", name, got, exp, tol);
   endtask

   task automatic do_reset();
      valid_in = 1'b0;
      ready    = 1'b0;
      clr_ovf  = 1'b0;
      rst      = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic push_sample(input int d);
      valid_in = 1'b1;
      data_in  = d;
      @(posedge clk);
      #1 valid_in = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int lat;
      int cnt;

      // k * 1.0 (Q24) scaled: k*72862523 + floor((5k+8)/16); k=8 hits an exact .5 tie
      kexp = '{72862523, 145725047, 218587570, 291450093, 364312617,
               437175140, 510037663, 582900187, 655762710};
      vecs[0] = '{0, 0, 0};
      vecs[1] = '{38630967, 167772160, 2};
      vecs[2] = '{-38630967, -167772160, 2};
      vecs[3] = '{1, 4, 0};
      vecs[4] = '{-1, -4, 0};
      for (int k = 0; k < 9; k++)
         vecs[5 + k] = '{(k + 1) * 16777216, kexp[k], 0};
      vecs[14] = '{-16777216, -72862523, 0};
      vecs[15] = '{-134217728, -582900186, 0};
`ifdef LOG_DB_SAT_EN
      vecs[16] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 0};
      vecs[17] = '{int'(32'h8000_0000), int'(32'h8000_0000), 0};
`else
      vecs[16] = '{32'h7FFF_FFFF, 736468388, 0};
      vecs[17] = '{int'(32'h8000_0000), -736468392, 0};
`endif

      b_valid_in = 1'b0;
      b_data_in  = '0;
      data_in    = '0;
      valid_in   = 1'b0;
      ready      = 1'b0;
      clr_ovf    = 1'b0;
      rst        = 1'b1;
      #3;
      chk("rst_valid", {31'b0, valid_out}, 32'd0);
      chk("rst_data", data_out, 32'd0);
      chk("rst_level", {28'b0, level}, 32'd0);
      chk("rst_ovf", {31'b0, overflow}, 32'd0);
      do_reset();

      // latency of a single sample into an empty FIFO
      ready = 1'b1;
      mon_en = 1'b1;
      valid_in = 1'b1;
      data_in = 38630967;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) valid_in = 1'b0;
         if (valid_out && lat == 0) begin
            lat = k;
            chk_tol("ln10_value", int'(data_out), 167772160, 2);
         end
      end
      chk("latency", lat, 32'd4);
      got_q.delete();

      // back-to-back table stream
      foreach (vecs[i]) begin
         valid_in = 1'b1;
         data_in  = vecs[i].din;
         @(posedge clk);
         #1;
      end
      valid_in = 1'b0;
      wait_cycles(10);
      chk("stream_count", got_q.size(), 32'd18);
      for (int i = 0; i < 18; i++) begin
         if (i < got_q.size())
            chk_tol($sformatf("vec%0d", i), int'(got_q[i]), vecs[i].exp, vecs[i].tol);
      end

      // fill, overflow on 9th, drain in order, clear flag
      do_reset();
      got_q.delete();
      for (int k = 1; k <= 9; k++)
         push_sample(k * 16777216);
      wait_cycles(6);
      chk("full_level", {28'b0, level}, 32'd8);
      chk("full_ovf", {31'b0, overflow}, 32'd1);
      chk("full_head", data_out, kexp[0]);
      chk("full_valid", {31'b0, valid_out}, 32'd1);
      ready = 1'b1;
      wait_cycles(12);
      ready = 1'b0;
      chk("drain_count", got_q.size(), 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < got_q.size())
            chk($sformatf("drain%0d", i), got_q[i], kexp[i]);
      end
      chk("empty_level", {28'b0, level}, 32'd0);
      chk("empty_valid", {31'b0, valid_out}, 32'd0);
      chk("empty_hold", data_out, kexp[7]);
      chk("ovf_sticky", {31'b0, overflow}, 32'd1);
      clr_ovf = 1'b1;
      wait_cycles(1);
      clr_ovf = 1'b0;
      chk("ovf_clear", {31'b0, overflow}, 32'd0);

      // full FIFO: push and pop in the same cycle
      do_reset();
      got_q.delete();
      for (int k = 1; k <= 8; k++)
         push_sample(k * 16777216);
      wait_cycles(5);
      chk("pp_pre_level", {28'b0, level}, 32'd8);
      push_sample(-134217728);
      wait_cycles(2);
      ready = 1'b1;
      wait_cycles(1);
      ready = 1'b0;
      chk("pp_level", {28'b0, level}, 32'd8);
      chk("pp_ovf", {31'b0, overflow}, 32'd0);
      chk("pp_head", data_out, kexp[1]);
      ready = 1'b1;
      wait_cycles(12);
      ready = 1'b0;
      chk("pp_count", got_q.size(), 32'd9);
      for (int i = 0; i < 9; i++) begin
         if (i < got_q.size())
            chk($sformatf("pp%0d", i), got_q[i], (i < 8) ? kexp[i] : -582900186);
      end

      // large COEF: wrap or clamp
      big_q.delete();
      b_valid_in = 1'b1;
      b_data_in = 32'h7FFF_FFFF;
      @(posedge clk);
      #1 b_data_in = 32'hFFFF_FFFF;
      @(posedge clk);
      #1 b_data_in = 32'h0100_0000;
      @(posedge clk);
      #1 b_valid_in = 1'b0;
      wait_cycles(8);
      chk("big_count", big_q.size(), 32'd3);
      if (big_q.size() == 3) begin
`ifdef LOG_DB_SAT_EN
         chk("big_max", big_q[0], 32'h7FFF_FFFF);
`else
         chk("big_max", big_q[0], 32'hFFFF_FFE8);
`endif
         chk("big_neg1", big_q[1], 32'hFFFF_FFF0);
         chk("big_one", big_q[2], 32'h1000_0000);
      end

      // async reset with 3 in flight and 5 queued
      do_reset();
      got_q.delete();
      for (int k = 1; k <= 8; k++)
         push_sample(k * 16777216);
      chk("flush_pre_level", {28'b0, level}, 32'd5);
      #2 rst = 1'b1;
      #1;
      chk("flush_valid", {31'b0, valid_out}, 32'd0);
      chk("flush_data", data_out, 32'd0);
      chk("flush_level", {28'b0, level}, 32'd0);
      chk("flush_ovf", {31'b0, overflow}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      ready = 1'b1;
      cnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (valid_out) cnt++;
      end
      chk("flush_no_emit", cnt, 32'd0);
      chk("flush_post_level", {28'b0, level}, 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
